// File: rtl/pipe_pkg.sv
// Shared widths and occupancy encodings for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 48;
    localparam int unsigned PIPE_DATA_W = 160;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry of the stage: control field cleared on reset/clear, data field
// always cleared on reset and optionally on clear.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned DATA_W   = PIPE_DATA_W,
    parameter bit          CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr_i) begin
            ctrl_d = '0;
            // Datapath bits normally survive a kill; only the control field must become a NOP.
            if (CLR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            ctrl_d = ctrl_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. Define PIPE_STAGE_SKID_EN for the 2-entry skid
// form with a registered in_ready_o; otherwise a single register with pass-through ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned DATA_W   = PIPE_DATA_W,
    parameter bit          CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;
    logic [CTRL_W-1:0] main_ctrl;

`ifdef PIPE_STAGE_SKID_EN

    occ_e              state_q, state_d;
    logic              skid_load;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Ready depends on registered state only, cutting the out_ready_i -> in_ready_o path.
    assign in_ready_o  = (state_q != StFull);
    assign out_valid_o = (state_q != StEmpty);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign occupancy_o = state_q;

    always_comb begin
        state_d      = state_q;
        main_load    = 1'b0;
        skid_load    = 1'b0;
        main_ctrl_in = in_ctrl_i;
        main_data_in = in_data_i;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d   = StOne;
                        main_load = 1'b1;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = StFull;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // Oldest beat leaves; the skid beat becomes the head.
                    if (out_fire) begin
                        state_d      = StOne;
                        main_load    = 1'b1;
                        main_ctrl_in = skid_ctrl;
                        main_data_in = skid_data;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_stage_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .clr_i  (flush_i),
        .ctrl_i (in_ctrl_i),
        .data_i (in_data_i),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );

`else

    logic valid_q, valid_d;

    assign in_ready_o  = out_ready_i | ~valid_q;
    assign out_valid_o = valid_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign occupancy_o = {1'b0, valid_q};

    always_comb begin
        valid_d      = valid_q;
        main_load    = 1'b0;
        main_ctrl_in = in_ctrl_i;
        main_data_in = in_data_i;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d   = 1'b1;
            main_load = 1'b1;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

`endif

    pipe_stage_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (main_load),
        .clr_i  (flush_i),
        .ctrl_i (main_ctrl_in),
        .data_i (main_data_in),
        .ctrl_o (main_ctrl),
        .data_o (out_data_o)
    );

    // A drained stage keeps stale control bits in the slot; present a NOP instead.
    assign out_ctrl_o = out_valid_o ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg in whichever form the build selects.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned CW = PIPE_CTRL_W;
    localparam int unsigned DW = PIPE_DATA_W;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          out_ready_i;
    logic [CW-1:0] in_ctrl_i;
    logic [DW-1:0] in_data_i;

    logic          in_ready_o,  c_in_ready_o;
    logic          out_valid_o, c_out_valid_o;
    logic [CW-1:0] out_ctrl_o,  c_out_ctrl_o;
    logic [DW-1:0] out_data_o,  c_out_data_o;
    logic [1:0]    occupancy_o, c_occupancy_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1'b1)) dut_clr (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (c_in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (c_out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (c_out_ctrl_o),
        .out_data_o  (c_out_data_o),
        .occupancy_o (c_occupancy_o)
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_ctrl_i   = '0;
        in_data_i   = '0;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid_i = 1'b1;
        in_ctrl_i  = c;
        in_data_i  = d;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        #1;
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid: got %0h want 0", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== '0) $display("FAIL rst_ctrl: got %0h want 0", out_ctrl_o); else n_pass++;
        n_chk++; if (out_data_o !== '0) $display("FAIL rst_data: got %0h want 0", out_data_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy_o); else n_pass++;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %0h want 1", in_ready_o); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        idle();
        out_ready_i = 1'b1;
        offer(48'h0000_0000_00A5, 160'h1234);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL single_in_ready: got %0h want 1", in_ready_o); else n_pass++;
        step();
        in_valid_i = 1'b0;
        n_chk++; if (out_valid_o !== 1'b1) $display("FAIL single_valid: got %0h want 1", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== 48'hA5) $display("FAIL single_ctrl: got %0h want a5", out_ctrl_o); else n_pass++;
        n_chk++; if (out_data_o !== 160'h1234) $display("FAIL single_data: got %0h want 1234", out_data_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd1) $display("FAIL single_occ: got %0d want 1", occupancy_o); else n_pass++;
        step();
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL bubble_valid: got %0h want 0", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== '0) $display("FAIL bubble_ctrl: got %0h want 0", out_ctrl_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL bubble_occ: got %0d want 0", occupancy_o); else n_pass++;
    endtask

    task automatic test_skid_fill();
        logic [CW-1:0] beats [3];
        int in_idx;
        int out_idx;
        logic in_f;
        logic out_f;
        beats[0] = 48'h11;
        beats[1] = 48'h22;
        beats[2] = 48'h33;
        idle();
        offer(beats[0], 160'h11);
        #1;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL fill_rdy0: got %0h want 1", in_ready_o); else n_pass++;
        step();
        offer(beats[1], 160'h22);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL fill_rdy1: got %0h want 1", in_ready_o); else n_pass++;
        step();
        offer(beats[2], 160'h33);
        #1;
        n_chk++; if (in_ready_o !== 1'b0) $display("FAIL fill_rdy2: got %0h want 0", in_ready_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd2) $display("FAIL fill_occ: got %0d want 2", occupancy_o); else n_pass++;
        in_idx = 2;
`else
        n_chk++; if (in_ready_o !== 1'b0) $display("FAIL fill_rdy1: got %0h want 0", in_ready_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd1) $display("FAIL fill_occ: got %0d want 1", occupancy_o); else n_pass++;
        in_idx = 1;
`endif
        n_chk++; if (out_ctrl_o !== beats[0]) $display("FAIL fill_head: got %0h want 11", out_ctrl_o); else n_pass++;
        out_idx = 0;
        out_ready_i = 1'b1;
        for (int cyc = 0; cyc < 12 && out_idx < 3; cyc++) begin
            #1;
            in_f  = in_valid_i & in_ready_o;
            out_f = out_valid_o & out_ready_i;
            if (out_f) begin
                n_chk++;
                if (out_ctrl_o !== beats[out_idx])
                    $display("FAIL drain_order: got %0h want %0h", out_ctrl_o, beats[out_idx]);
                else n_pass++;
                out_idx++;
            end
            step();
            if (in_f) begin
                in_idx++;
                if (in_idx < 3) offer(beats[in_idx], DW'(beats[in_idx]));
                else in_valid_i = 1'b0;
            end
        end
        n_chk++; if (out_idx !== 3) $display("FAIL drain_count: got %0d want 3", out_idx); else n_pass++;
        in_valid_i = 1'b0;
        step();
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL drain_empty: got %0h want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_flush();
        idle();
        offer(48'h55, 160'hDEAD_BEEF);
        step();
`ifdef PIPE_STAGE_SKID_EN
        offer(48'h66, 160'h6666);
        step();
        n_chk++; if (occupancy_o !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy_o); else n_pass++;
`else
        n_chk++; if (occupancy_o !== 2'd1) $display("FAIL flush_pre_occ: got %0d want 1", occupancy_o); else n_pass++;
`endif
        n_chk++; if (out_data_o !== 160'hDEAD_BEEF) $display("FAIL flush_pre_data: got %0h want deadbeef", out_data_o); else n_pass++;
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        offer(48'h44, 160'h44);
        step();
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        offer(48'h77, 160'h77);
        #1;
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL flush_valid: got %0h want 0", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== '0) $display("FAIL flush_ctrl: got %0h want 0", out_ctrl_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy_o); else n_pass++;
        n_chk++; if (out_data_o !== 160'hDEAD_BEEF) $display("FAIL flush_hold_data: got %0h want deadbeef", out_data_o); else n_pass++;
        n_chk++; if (c_out_data_o !== '0) $display("FAIL flush_clr_data: got %0h want 0", c_out_data_o); else n_pass++;
        n_chk++; if (c_out_ctrl_o !== '0) $display("FAIL flush_clr_ctrl: got %0h want 0", c_out_ctrl_o); else n_pass++;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL flush_in_ready: got %0h want 1", in_ready_o); else n_pass++;
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        n_chk++; if (out_valid_o !== 1'b1) $display("FAIL post_flush_valid: got %0h want 1", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== 48'h77) $display("FAIL post_flush_ctrl: got %0h want 77", out_ctrl_o); else n_pass++;
        step();
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL post_flush_empty: got %0h want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        offer(48'h88, 160'h88);
        step();
`ifdef PIPE_STAGE_SKID_EN
        offer(48'h99, 160'h99);
        step();
        n_chk++; if (occupancy_o !== 2'd2) $display("FAIL rmid_pre_occ: got %0d want 2", occupancy_o); else n_pass++;
`else
        n_chk++; if (occupancy_o !== 2'd1) $display("FAIL rmid_pre_occ: got %0d want 1", occupancy_o); else n_pass++;
`endif
        rst_n   = 1'b0;
        flush_i = 1'b1;
        offer(48'hAA, 160'hAA);
        step();
        rst_n      = 1'b1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL rmid_valid: got %0h want 0", out_valid_o); else n_pass++;
        n_chk++; if (out_ctrl_o !== '0) $display("FAIL rmid_ctrl: got %0h want 0", out_ctrl_o); else n_pass++;
        n_chk++; if (out_data_o !== '0) $display("FAIL rmid_data: got %0h want 0", out_data_o); else n_pass++;
        n_chk++; if (occupancy_o !== 2'd0) $display("FAIL rmid_occ: got %0d want 0", occupancy_o); else n_pass++;
        n_chk++; if (in_ready_o !== 1'b1) $display("FAIL rmid_in_ready: got %0h want 1", in_ready_o); else n_pass++;
        out_ready_i = 1'b1;
        step();
        n_chk++; if (out_valid_o !== 1'b0) $display("FAIL rmid_discard: got %0h want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t b;
        logic [63:0] r64;
        logic in_f;
        logic out_f;
        logic rdy_a;
        idle();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            n_chk++;
            if (out_valid_o !== (q.size() != 0))
                $display("FAIL rnd_valid @%0d: got %0h want %0h", cyc, out_valid_o, q.size() != 0);
            else n_pass++;
            n_chk++;
            if (occupancy_o !== 2'(q.size()))
                $display("FAIL rnd_occ @%0d: got %0d want %0d", cyc, occupancy_o, q.size());
            else n_pass++;
            if (q.size() != 0) begin
                n_chk++;
                if (out_ctrl_o !== q[0].c || out_data_o !== q[0].d)
                    $display("FAIL rnd_beat @%0d: got %0h want %0h", cyc, out_ctrl_o, q[0].c);
                else n_pass++;
            end else begin
                n_chk++;
                if (out_ctrl_o !== '0)
                    $display("FAIL rnd_bubble @%0d: got %0h want 0", cyc, out_ctrl_o);
                else n_pass++;
            end
            in_valid_i  = ($urandom_range(0, 9) < 7);
            out_ready_i = ($urandom_range(0, 9) < 6);
            r64         = {$urandom, $urandom};
            in_ctrl_i   = r64[CW-1:0];
            in_data_i   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
`ifdef PIPE_STAGE_SKID_EN
            n_chk++;
            if (in_ready_o !== (q.size() < 2))
                $display("FAIL rnd_in_ready @%0d: got %0h want %0h", cyc, in_ready_o, q.size() < 2);
            else n_pass++;
            rdy_a       = in_ready_o;
            out_ready_i = ~out_ready_i;
            #1;
            n_chk++;
            if (in_ready_o !== rdy_a)
                $display("FAIL rnd_ready_path @%0d: got %0h want %0h", cyc, in_ready_o, rdy_a);
            else n_pass++;
            out_ready_i = ~out_ready_i;
            #1;
`else
            rdy_a = out_ready_i | (q.size() == 0);
            n_chk++;
            if (in_ready_o !== rdy_a)
                $display("FAIL rnd_in_ready @%0d: got %0h want %0h", cyc, in_ready_o, rdy_a);
            else n_pass++;
`endif
            in_f  = in_valid_i & in_ready_o;
            out_f = out_valid_o & out_ready_i;
            b.c   = in_ctrl_i;
            b.d   = in_data_i;
            step();
            if (out_f && q.size() != 0) void'(q.pop_front());
            if (in_f) q.push_back(b);
        end
        idle();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_skid_fill();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
